mux_scheduler_rr: RTL
=====================

Name: mux_scheduler_rr

Overview:
- Round-robin scheduler that shares the 2:1 data mux between two requesting sources and drives its selector.
- Each source presents a word with a valid flag. The block grants one source per cycle and pops it.
- The granted word is registered onto data_out with valid_out, under a downstream ready handshake.
- A burst limit bounds how long one source can hold the mux while the other is waiting.

Parameters:
- BW, 2, data width of each source and of data_out.
- MAX_BURST, 2, max consecutive grants to one source while the other is valid (range 1..15).
- CW, 4, width of the burst counter (must hold MAX_BURST).

Ports:
- clok  input  1  clock, rising edge.
- reset_L  input  1  asynchronous active-low reset.
- valid_in0  input  1  source 0 has a word.
- data_in0  input  BW  source 0 word.
- valid_in1  input  1  source 1 has a word.
- data_in1  input  BW  source 1 word.
- dst_ready  input  1  downstream accepts data_out this cycle.
- pop_0  output  1  combinational; source 0 word consumed this cycle.
- pop_1  output  1  combinational; source 1 word consumed this cycle.
- selector  output  1  registered; source id of the word currently on data_out.
- data_out  output  BW  registered output word.
- valid_out  output  1  registered; data_out is valid.

Behaviour:
- Reset (async, reset_L=0): data_out=0, valid_out=0, selector=0, state=IDLE, burst_cnt=0, last=1 (source 0 wins the first tie). pop_0 and pop_1 are 0 while reset is asserted.
- load_en = !valid_out || dst_ready. No grant occurs when load_en=0; all outputs hold and both pops are 0.
- States:
  - IDLE: no current owner.
  - SERVE0: source 0 owns the mux.
  - SERVE1: source 1 owns the mux.
- Grant decision (combinational, only when load_en=1):
  - IDLE, one valid: grant that source.
  - IDLE, both valid: grant !last.
  - SERVEx, only x valid: grant x. burst_cnt saturates at MAX_BURST.
  - SERVEx, only y valid: grant y.
  - SERVEx, both valid, burst_cnt < MAX_BURST: grant x.
  - SERVEx, both valid, burst_cnt == MAX_BURST: grant y.
  - Neither valid: no grant, next state IDLE, burst_cnt=0.
- On a grant to g:
  - pop_g=1 in the same cycle.
  - Next edge: data_out=data_in_g, selector=g, valid_out=1, last=g, state=SERVEg.
  - burst_cnt = 1 if g differs from the previous owner or the state was IDLE; otherwise min(burst_cnt+1, MAX_BURST).
- load_en=1 with no grant: valid_out=0 at the next edge. data_out and selector hold.
- Latency: one cycle from pop to valid_out. With dst_ready held at 1, the block sustains one word per cycle.
- pop_0 and pop_1 are never both 1.
- Reset mid-burst: everything returns to reset values immediately. No word is popped during reset.

Optional Feature:
- Macro MUX_SCHED_STATS_EN.
- Defined:
  - Adds outputs cnt_grant0[5:0] and cnt_grant1[5:0], each counting grants to its source.
  - Counters saturate at 63 and reset to 0.
  - Adds input stats_clr, a synchronous clear; a clear has priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package mux_sched_pkg: state encodings IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2; default BW; STATS_W=6.
- One sub-module, mux_sched_sat_cnt: parameterised width and limit; inputs clr, inc; saturating.
  - Instantiated for the burst counter.
  - Instantiated twice more for the stats counters when MUX_SCHED_STATS_EN is defined.

Test Plan (BW=2, MAX_BURST=2):
- Reset then idle: reset_L=0 for 2 cycles, then valids=0 → all outputs 0, pops 0, state IDLE.
- Single source: valid_in0=1, data_in0=2'b10, dst_ready=1 for 4 cycles → pop_0 every cycle; data_out=2'b10, selector=0, valid_out=1 from cycle 2. pop_1 never asserts.
- Contention: both valid for 6 cycles, data_in0=2'b01, data_in1=2'b11, dst_ready=1 → grant order 0,0,1,1,0,0. selector out 0,0,1,1,0,0 delayed one cycle.
- Backpressure: dst_ready=0 while valid_out=1 for 3 cycles → pops 0; data_out, selector, valid_out held. When dst_ready=1, the grant resumes from the held burst state.
- Async reset mid-burst: reset_L low between edges during SERVE1 with burst_cnt=1 → valid_out=0 immediately. After release, first grant goes to source 0 when both are valid.
- With MUX_SCHED_STATS_EN: 70 grants to source 0 → cnt_grant0=63. stats_clr=1 for one cycle → 0.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package mux_sched_pkg;

  // Scheduler ownership state: who currently holds the mux
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam int DEFAULT_BW = 2;
  localparam int STATS_W    = 6;

endpackage

// File: rtl/mux_sched_sat_cnt.sv
// Saturating up-counter with synchronous clear and load.
// Latency: count visible one cycle after clr/ld/inc.
// Backpressure: none; clr beats ld, ld beats inc, inc stops at LIMIT.
`timescale 1ns/1ps
module mux_sched_sat_cnt #(
  parameter int W     = 4,
  parameter int LIMIT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  // Count register: clear first, then load, then saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mux_scheduler_rr.sv
// Round-robin 2:1 mux scheduler with burst limit; optional grant stats (MUX_SCHED_STATS_EN).
// Latency: one cycle from pop_x to valid_out/data_out; one word per cycle with dst_ready high.
// Backpressure: when valid_out is held and dst_ready is low, no grant, pops low, outputs hold.
`timescale 1ns/1ps
module mux_scheduler_rr
  import mux_sched_pkg::*;
#(
  parameter int BW        = DEFAULT_BW,
  parameter int MAX_BURST = 2,
  parameter int CW        = 4
) (
  input  logic               clok,
  input  logic               reset_L,
`ifdef MUX_SCHED_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] cnt_grant0,
  output logic [STATS_W-1:0] cnt_grant1,
`endif
  input  logic               valid_in0,
  input  logic [BW-1:0]      data_in0,
  input  logic               valid_in1,
  input  logic [BW-1:0]      data_in1,
  input  logic               dst_ready,
  output logic               pop_0,
  output logic               pop_1,
  output logic               selector,
  output logic [BW-1:0]      data_out,
  output logic               valid_out
);

  state_t        state;
  logic          last;
  logic [CW-1:0] burst_cnt;
  logic          load_en;
  logic          owner;
  logic          grant_vld;
  logic          grant_id;
  logic          burst_restart;

  assign load_en = !valid_out || dst_ready;
  assign owner   = (state == SERVE1);

  // Grant decision: sticky to the owner until its burst is spent and the other side waits
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (load_en) begin
      if (valid_in0 && valid_in1) begin
        grant_vld = 1'b1;
        if (state == IDLE) begin
          grant_id = !last;
        end else if (burst_cnt < CW'(MAX_BURST)) begin
          grant_id = owner;
        end else begin
          grant_id = !owner;
        end
      end else if (valid_in0) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (valid_in1) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  // Pops are suppressed while reset is held so no source word is lost
  assign pop_0 = reset_L && grant_vld && !grant_id;
  assign pop_1 = reset_L && grant_vld &&  grant_id;

  // A new owner (or leaving IDLE) restarts the burst at one grant
  assign burst_restart = grant_vld && ((state == IDLE) || (grant_id != owner));

  mux_sched_sat_cnt #(
    .W     (CW),
    .LIMIT (MAX_BURST)
  ) u_burst_cnt (
    .clk    (clok),
    .rst_n  (reset_L),
    .clr    (load_en && !grant_vld),
    .ld     (burst_restart),
    .ld_val (CW'(1)),
    .inc    (grant_vld && !burst_restart),
    .cnt    (burst_cnt)
  );

  // Output register and ownership state, advanced only when the output slot is free
  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      last      <= 1'b1;
      selector  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load_en) begin
      if (grant_vld) begin
        data_out  <= grant_id ? data_in1 : data_in0;
        selector  <= grant_id;
        valid_out <= 1'b1;
        last      <= grant_id;
        state     <= grant_id ? SERVE1 : SERVE0;
      end else begin
        valid_out <= 1'b0;
        state     <= IDLE;
      end
    end
  end

`ifdef MUX_SCHED_STATS_EN
  mux_sched_sat_cnt #(
    .W     (STATS_W),
    .LIMIT ((1 << STATS_W) - 1)
  ) u_stat0 (
    .clk    (clok),
    .rst_n  (reset_L),
    .clr    (stats_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (pop_0),
    .cnt    (cnt_grant0)
  );

  mux_sched_sat_cnt #(
    .W     (STATS_W),
    .LIMIT ((1 << STATS_W) - 1)
  ) u_stat1 (
    .clk    (clok),
    .rst_n  (reset_L),
    .clr    (stats_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (pop_1),
    .cnt    (cnt_grant1)
  );
`endif

endmodule
